// File: rtl/gf256_sqscmul_dom.sv
// gf256_sqscmul_dom
//   Masked GF(2^8) norm stage of a DOM AES S-box. For a shared tower-field
//   byte X = H*y ^ L it produces the shared GF(2^4) value
//   D = mu*H^2 ^ L^2 ^ H*L, with one DOM-indep multiplication register
//   stage. H and L are also passed through an HL_DELAY-deep delay line for
//   the downstream GF(2^8) output multipliers.
// Ports
//   ClkxCI, RstxBI     clock (rising), async active-low reset
//   EnxSI              global enable; low holds every register
//   ValidxSI/ValidxSO  input valid / D valid (1 enabled cycle later)
//   _XxDI              shares of X, share i at [8i+7:8i] (H high nibble)
//   _ZxDI              fresh 4-bit randomness per share pair i<j, lexicographic
//   _DxDO              shares of D, share i at [4i+3:4i]
//   _HxDO/_LxDO        H/L shares delayed HL_DELAY enabled cycles
//   HLValidxSO         ValidxSI delayed HL_DELAY enabled cycles

// Per-share row of DOM terms. Element j of the row is H_i*L_j masked by the
// pair randomness; the diagonal (j == IDX) carries the inner product plus the
// share-local linear part instead (its z_row entry is tied to zero).
module gf256_sqscmul_dom_lane #(
  parameter int SHARES = 2,
  parameter int IDX    = 0
) (
  input  logic [3:0]             h_i,
  input  logic [SHARES-1:0][3:0] l_all,
  input  logic [SHARES-1:0][3:0] z_row,
  output logic [SHARES-1:0][3:0] row_d
);
  // GF(2^2), basis (w,1)
  function automatic logic [1:0] m2(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // GF(2^4) over GF(2^2), z^2 = z ^ w
  function automatic logic [3:0] m4(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh = m2(a[3:2], b[3:2]);
    return {hh ^ m2(a[3:2], b[1:0]) ^ m2(a[1:0], b[3:2]),
            m2(2'b10, hh) ^ m2(a[1:0], b[1:0])};
  endfunction

  function automatic logic [3:0] sq4(input logic [3:0] a);
    logic [1:0] hs, ls;
    hs = {a[3], a[3] ^ a[2]};
    ls = {a[1], a[1] ^ a[0]};
    return {hs, m2(2'b10, hs) ^ ls};
  endfunction

  logic [3:0] lin;

  // mu = w*z (4'b1000)
  assign lin = m4(4'h8, sq4(h_i)) ^ sq4(l_all[IDX]);

  always_comb begin
    row_d = '0;
    for (int j = 0; j < SHARES; j++)
      row_d[j] = m4(h_i, l_all[j]) ^ z_row[j] ^ ((j == IDX) ? lin : 4'h0);
  end
endmodule

module gf256_sqscmul_dom #(
  parameter int SHARES   = 2,
  parameter int HL_DELAY = 3
) (
  input  logic                           ClkxCI,
  input  logic                           RstxBI,
  input  logic                           EnxSI,
  input  logic                           ValidxSI,
  input  logic [8*SHARES-1:0]            _XxDI,
  input  logic [2*SHARES*(SHARES-1)-1:0] _ZxDI,
  output logic [4*SHARES-1:0]            _DxDO,
  output logic                           ValidxSO,
  output logic [4*SHARES-1:0]            _HxDO,
  output logic [4*SHARES-1:0]            _LxDO,
  output logic                           HLValidxSO
);
  if (SHARES < 2) begin : g_bad_shares
    $error("gf256_sqscmul_dom: SHARES must be >= 2");
  end
  if (HL_DELAY < 1) begin : g_bad_delay
    $error("gf256_sqscmul_dom: HL_DELAY must be >= 1");
  end

  // index of pair (i,j), i<j, in lexicographic order
  function automatic int pair_idx(input int i, input int j);
    return i * (2 * SHARES - i - 1) / 2 + (j - i - 1);
  endfunction

  logic [SHARES-1:0][3:0]             x_h, x_l;
  logic [SHARES-1:0][SHARES-1:0][3:0] z_mat, cross_t, cross_d, cross_q;
  logic                               vld_d, vld_q;
  logic [HL_DELAY-1:0][8*SHARES-1:0]  x_dly_d, x_dly_q;
  logic [HL_DELAY-1:0]                hl_vld_d, hl_vld_q;

  for (genvar i = 0; i < SHARES; i++) begin : g_share
    assign x_h[i] = _XxDI[8*i+4 +: 4];
    assign x_l[i] = _XxDI[8*i   +: 4];

    // (i,j) and (j,i) share the same pair word
    for (genvar j = 0; j < SHARES; j++) begin : g_pair
      if (i < j) begin : g_lo
        localparam int P = pair_idx(i, j);
        assign z_mat[i][j] = _ZxDI[4*P +: 4];
      end else if (i > j) begin : g_hi
        localparam int P = pair_idx(j, i);
        assign z_mat[i][j] = _ZxDI[4*P +: 4];
      end else begin : g_diag
        assign z_mat[i][j] = 4'h0;
      end
    end

    gf256_sqscmul_dom_lane #(.SHARES(SHARES), .IDX(i)) u_lane (
      .h_i   (x_h[i]),
      .l_all (x_l),
      .z_row (z_mat[i]),
      .row_d (cross_t[i])
    );

    assign _HxDO[4*i +: 4] = x_dly_q[HL_DELAY-1][8*i+4 +: 4];
    assign _LxDO[4*i +: 4] = x_dly_q[HL_DELAY-1][8*i   +: 4];
  end

  always_comb begin
    cross_d  = cross_q;
    vld_d    = vld_q;
    x_dly_d  = x_dly_q;
    hl_vld_d = hl_vld_q;
    if (EnxSI) begin
      cross_d     = cross_t;
      vld_d       = ValidxSI;
      x_dly_d[0]  = _XxDI;
      hl_vld_d[0] = ValidxSI;
      for (int k = 1; k < HL_DELAY; k++) begin
        x_dly_d[k]  = x_dly_q[k-1];
        hl_vld_d[k] = hl_vld_q[k-1];
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      cross_q  <= '0;
      vld_q    <= 1'b0;
      x_dly_q  <= '0;
      hl_vld_q <= '0;
    end else begin
      cross_q  <= cross_d;
      vld_q    <= vld_d;
      x_dly_q  <= x_dly_d;
      hl_vld_q <= hl_vld_d;
    end
  end

  // Recombination only after every term has been registered.
  always_comb begin
    _DxDO = '0;
    for (int i = 0; i < SHARES; i++)
      for (int j = 0; j < SHARES; j++)
        _DxDO[4*i +: 4] = _DxDO[4*i +: 4] ^ cross_q[i][j];
  end

  assign ValidxSO   = vld_q;
  assign HLValidxSO = hl_vld_q[HL_DELAY-1];
endmodule

// File: tb/tb_gf256_sqscmul_dom.sv
module tb_gf256_sqscmul_dom;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b1;
  logic        vin = 1'b0;
  logic [15:0] x2 = '0;
  logic [3:0]  z2 = '0;
  logic [23:0] x3 = '0;
  logic [11:0] z3 = '0;
  logic [7:0]  d2, h2, l2;
  logic [11:0] d3, h3, l3;
  logic        v2o, hlv2, v3o, hlv3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gf256_sqscmul_dom #(.SHARES(2), .HL_DELAY(3)) u_dut2 (
    .ClkxCI(clk), .RstxBI(rst_n), .EnxSI(en), .ValidxSI(vin),
    ._XxDI(x2), ._ZxDI(z2), ._DxDO(d2), .ValidxSO(v2o),
    ._HxDO(h2), ._LxDO(l2), .HLValidxSO(hlv2)
  );

  gf256_sqscmul_dom #(.SHARES(3), .HL_DELAY(3)) u_dut3 (
    .ClkxCI(clk), .RstxBI(rst_n), .EnxSI(en), .ValidxSI(vin),
    ._XxDI(x3), ._ZxDI(z3), ._DxDO(d3), .ValidxSO(v3o),
    ._HxDO(h3), ._LxDO(l3), .HLValidxSO(hlv3)
  );

  // ---------------- reference arithmetic (unmasked) ----------------
  function automatic logic [1:0] gm2(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // (ah z + al)(bh z + bl) reduced with z^2 = z + w
  function automatic logic [3:0] gm4(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, hl, lh, ll;
    hh = gm2(a[3:2], b[3:2]); hl = gm2(a[3:2], b[1:0]);
    lh = gm2(a[1:0], b[3:2]); ll = gm2(a[1:0], b[1:0]);
    return {hh ^ hl ^ lh, gm2(2'b10, hh) ^ ll};
  endfunction

  function automatic logic [3:0] norm(input logic [7:0] x);
    return gm4(4'h8, gm4(x[7:4], x[7:4])) ^ gm4(x[3:0], x[3:0]) ^ gm4(x[7:4], x[3:0]);
  endfunction

  function automatic logic [7:0] u2(input logic [15:0] x);
    return x[7:0] ^ x[15:8];
  endfunction
  function automatic logic [7:0] u3(input logic [23:0] x);
    return x[7:0] ^ x[15:8] ^ x[23:16];
  endfunction
  function automatic logic [3:0] f2(input logic [7:0] d);
    return d[3:0] ^ d[7:4];
  endfunction
  function automatic logic [3:0] f3(input logic [11:0] d);
    return d[3:0] ^ d[7:4] ^ d[11:8];
  endfunction

  // ---------------- behavioural model ----------------
  logic [3:0]  e_d2 = '0, e_d3 = '0;
  logic        e_v = 1'b0;
  logic [16:0] hlq[$] = '{17'h0, 17'h0, 17'h0};  // {valid, X2 unmasked, X3 unmasked}

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_d2 <= '0; e_d3 <= '0; e_v <= 1'b0;
      hlq.delete();
      for (int k = 0; k < 3; k++) hlq.push_back(17'h0);
    end else if (en) begin
      e_d2 <= norm(u2(x2));
      e_d3 <= norm(u3(x3));
      e_v  <= vin;
      hlq.push_back({vin, u2(x2), u3(x3)});
      void'(hlq.pop_front());
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] xa, input logic [7:0] xb, input bit masked,
                        input logic v);
    logic [7:0] r0, r1, r2;
    vin = v;
    if (masked) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      x2 = {xa ^ r0, r0};
      x3 = {xb ^ r1 ^ r2, r2, r1};
      z2 = 4'($urandom);
      z3 = 12'($urandom);
    end else begin
      x2 = {8'h00, xa};
      x3 = {16'h0000, xb};
      z2 = '0;
      z3 = '0;
    end
  endtask

  task automatic check_all();
    chk("d2_model", 16'(f2(d2)), 16'(e_d2));
    chk("d3_model", 16'(f3(d3)), 16'(e_d3));
    chk("v2_model", 16'(v2o), 16'(e_v));
    chk("v3_model", 16'(v3o), 16'(e_v));
    chk("hlv2_model", 16'(hlv2), 16'(hlq[0][16]));
    chk("hlv3_model", 16'(hlv3), 16'(hlq[0][16]));
    chk("h2_model", 16'(f2(h2)), 16'(hlq[0][15:12]));
    chk("l2_model", 16'(f2(l2)), 16'(hlq[0][11:8]));
    chk("h3_model", 16'(f3(h3)), 16'(hlq[0][7:4]));
    chk("l3_model", 16'(f3(l3)), 16'(hlq[0][3:0]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d2"}, 16'(d2), 16'h0);
    chk({tag, "_d3"}, 16'(d3), 16'h0);
    chk({tag, "_v"}, 16'({v2o, v3o}), 16'h0);
    chk({tag, "_hlv"}, 16'({hlv2, hlv3}), 16'h0);
    chk({tag, "_h2l2"}, {h2, l2}, 16'h0);
    chk({tag, "_h3"}, 16'(h3), 16'h0);
    chk({tag, "_l3"}, 16'(l3), 16'h0);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [3:0] d;
  } vec_t;

  initial begin
    vec_t vecs[5];
    bit [15:0] seen_d0;
    int n_seen;

    vecs[0] = '{x: 8'h00, d: 4'h0};
    vecs[1] = '{x: 8'h01, d: 4'h1};
    vecs[2] = '{x: 8'h10, d: 4'h8};
    vecs[3] = '{x: 8'h11, d: 4'h8};
    vecs[4] = '{x: 8'h40, d: 4'h7};

    // reset state
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    tick();
    chk_zero("rst");
    check_all();
    tick();
    rst_n = 1'b1;

    // unmasked vectors
    for (int k = 0; k < 5; k++) begin
      set_in(vecs[k].x, vecs[k].x, 1'b0, 1'b1);
      tick();
      chk($sformatf("vec%0d_d2", k), 16'(f2(d2)), 16'(vecs[k].d));
      chk($sformatf("vec%0d_d3", k), 16'(f3(d3)), 16'(vecs[k].d));
      chk($sformatf("vec%0d_v", k), 16'(v2o), 16'h1);
      check_all();
    end

    // masked invariance on the 2-share instance
    seen_d0 = '0;
    for (int k = 0; k < 1000; k++) begin
      set_in(8'h11, 8'($urandom), 1'b1, 1'b1);
      x2 = 16'hA5B4;
      tick();
      chk("inv_d2", 16'(f2(d2)), 16'h8);
      seen_d0[d2[3:0]] = 1'b1;
      if (k % 50 == 0) check_all();
    end
    n_seen = $countones(seen_d0);
    chk("inv_d0_varies", 16'(n_seen > 1), 16'h1);

    // exhaustive on the 3-share instance
    for (int x = 0; x < 256; x++) begin
      set_in(8'($urandom), 8'(x), 1'b1, 1'b1);
      tick();
      chk("exh_d3", 16'(f3(d3)), 16'(norm(8'(x))));
      check_all();
    end

    // delay line: single valid pulse X=4C
    for (int k = 0; k < 3; k++) begin
      set_in(8'($urandom), 8'($urandom), 1'b1, 1'b0);
      tick();
      check_all();
    end
    set_in(8'h4C, 8'h4C, 1'b1, 1'b1);
    tick();
    chk("dly_v_c1", 16'(v2o), 16'h1);
    chk("dly_hlv_c1", 16'(hlv2), 16'h0);
    check_all();
    set_in(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    tick();
    chk("dly_hlv_c2", 16'({hlv2, hlv3}), 16'h0);
    check_all();
    set_in(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    tick();
    chk("dly_hlv_c3", 16'({hlv2, hlv3}), 16'h3);
    chk("dly_hl2", {8'h00, f2(h2), f2(l2)}, 16'h004C);
    chk("dly_hl3", {8'h00, f3(h3), f3(l3)}, 16'h004C);
    check_all();
    tick();
    chk("dly_hlv_c4", 16'(hlv2), 16'h0);
    check_all();

    // enable hold
    for (int k = 0; k < 3; k++) begin
      set_in(8'($urandom), 8'($urandom), 1'b1, 1'b0);
      tick();
    end
    set_in(8'h40, 8'h40, 1'b1, 1'b1);
    tick();
    chk("hold_d_in", 16'({f2(d2), f3(d3)}), 16'h77);
    chk("hold_v_in", 16'(v2o), 16'h1);
    check_all();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(8'($urandom), 8'($urandom), 1'b1, 1'($urandom));
      tick();
      chk("hold_d", 16'({f2(d2), f3(d3)}), 16'h77);
      chk("hold_v", 16'({v2o, v3o}), 16'h3);
      chk("hold_hlv", 16'(hlv2), 16'h0);
      check_all();
    end
    en = 1'b1;
    set_in(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    tick();
    chk("hold_rel_v", 16'(v2o), 16'h0);
    chk("hold_rel_hlv1", 16'(hlv2), 16'h0);
    check_all();
    tick();
    chk("hold_rel_hlv2", 16'(hlv2), 16'h1);
    chk("hold_rel_hl2", {8'h00, f2(h2), f2(l2)}, 16'h0040);
    check_all();

    // reset mid-stream
    for (int k = 0; k < 5; k++) begin
      set_in(8'($urandom), 8'($urandom), 1'b1, 1'b1);
      tick();
      check_all();
    end
    rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    check_all();
    tick();
    chk_zero("mid_rst_clk");
    rst_n = 1'b1;
    set_in(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_v", 16'({v2o, v3o, hlv2, hlv3}), 16'h0);
      check_all();
    end

    // random stream with random holds
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(3) != 0);
      set_in(8'($urandom), 8'($urandom), 1'b1, 1'($urandom));
      tick();
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gf256_sqscmul_dom.md
# gf256_sqscmul_dom

Masked GF(2^8) norm stage of the DOM AES S-box: takes a shared tower-field byte X = H·y ⊕ L and produces the shared GF(2^4) norm D = μ·H² ⊕ L² ⊕ H·L.
- D feeds the GF(2^4) masked inverter.
- H and L are also delivered through a matched delay line to the downstream GF(2^8) output multipliers.
- Uses one DOM-indep multiplication with one register stage.
- Carries a valid flag and a global enable for pipeline holds.

## Interface
- SHARES, 2, number of Boolean shares (≥2).
- HL_DELAY, 3, cycles of delay on the H/L side outputs (≥1; 0 is an elaboration error).
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- EnxSI  in  1  global enable; low = every register holds.
- ValidxSI  in  1  input byte valid.
- _XxDI  in  8*SHARES  shared input; share i at [8i+7:8i]; H = [8i+7:8i+4], L = [8i+3:8i].
- _ZxDI  in  2*SHARES*(SHARES-1)  fresh randomness; one 4-bit word per pair i<j.
  - Pairs are in lexicographic order (0,1),(0,2)…; pair p at [4p+3:4p].
- _DxDO  out  4*SHARES  shared norm D; share i at [4i+3:4i].
- ValidxSO  out  1  D valid.
- _HxDO  out  4*SHARES  H shares delayed HL_DELAY cycles.
- _LxDO  out  4*SHARES  L shares delayed HL_DELAY cycles.
- HLValidxSO  out  1  H/L valid.

## Operation
Field arithmetic, all fixed:
- **GF(2^2)**, basis (w,1), w² = w⊕1.
  - Product of a = (a1,a0) and b = (b1,b0) is (a1b1⊕a1b0⊕a0b1, a1b1⊕a0b0).
  - Square of a is (a1, a1⊕a0).
- **GF(2^4)** = Ah·z ⊕ Al, with z² = z ⊕ λ and λ = w. Bits are {Ah1,Ah0,Al1,Al0}.
  - Product high = AhBh ⊕ AhBl ⊕ AlBh.
  - Product low = λ·AhBh ⊕ AlBl.
  - Square high = Ah²; square low = λ·Ah² ⊕ Al².
- **GF(2^8)** uses y² = y ⊕ μ, with μ = 4'b1000 (w·z, trace 1).

Per share i, linear term Lin_i = μ·H_i² ⊕ L_i², computed combinationally on that share only.

DOM multiplication, all terms registered before any recombination:
- Inner_i = reg(H_i·L_i ⊕ Lin_i).
- Cross_ij = reg(H_i·L_j ⊕ Z_p), for every i≠j, where p is the pair {i,j}. The same Z_p is used for (i,j) and (j,i).
- D_i = Inner_i ⊕ XOR over j≠i of Cross_ij. This is pure combinational recombination after the registers.
- No combinational path may mix shares before a register.

Valid and side outputs:
- ValidxSO = ValidxSI registered, so it is aligned with D.
- H/L delay line: HL_DELAY-deep shift register per share.
- HLValidxSO is a HL_DELAY-deep shift of ValidxSI.
- Data registers load regardless of ValidxSI; valid only tags the data.

Enable:
- EnxSI = 0: all registers (cross, inner, valid, delay line) hold their value; randomness is not sampled.
- EnxSI = 1: normal shift.
- Outputs during a hold show the held values.

## Timing
- Reset: all registers clear asynchronously to 0 the moment RstxBI falls.
  - Gives _DxDO = 0, ValidxSO = 0, _HxDO = 0, _LxDO = 0, HLValidxSO = 0.
  - Reset mid-stream discards all in-flight data.
  - First valid output after release requires a new ValidxSI.
- D latency = 1 enabled cycle. H/L latency = HL_DELAY enabled cycles.
- Throughput: one byte per enabled cycle; no back-pressure.
- _ZxDI is consumed in the same cycle as the corresponding _XxDI.
- Disabled cycles do not count toward latency. A byte in flight when EnxSI drops emerges after the remaining enabled cycles.
- Simultaneous reset and enable: reset wins.
- Unmasked D = XOR of all D_i, independent of Z and of the input share split.

## Test plan
- **Unmasked vectors** (SHARES=2, share1=0, Z=0), each output one cycle later with ValidxSO=1:
  - X=8'h00 → D=4'h0.
  - X=8'h01 → D=4'h1.
  - X=8'h10 → D=4'h8.
  - X=8'h11 → D=4'h8.
  - X=8'h40 → D=4'h7.
- **Masked invariance:** X=8'h11 split as share0=8'hB4, share1=8'hA5, Z random for 1000 cycles → D0⊕D1=4'h8 every cycle; individual shares vary.
- **Exhaustive** (SHARES=3): all 256 X values with random share splits and random Z → unmasked D matches a software model.
- **Delay line** (HL_DELAY=3): single valid pulse with X=8'h4C → HLValidxSO high exactly 3 cycles later, with unmasked H=4'h4 and L=4'hC; ValidxSO high after 1 cycle.
- **Enable hold:** drive valid X=8'h40, then EnxSI=0 for 5 cycles → outputs frozen; D=4'h7 appears one enabled cycle after the input; HLValidxSO is delayed by the 5 hold cycles.
- **Reset mid-stream:** streaming valid bytes, assert RstxBI low for 1 cycle → all outputs 0 immediately; no stale valid after release.
